// File: rtl/conv_cfg_writer.sv
// conv_cfg_writer: hardware AXI-Lite write initiator that programs the
// convolution controller register map (soft reset, enable, width, height,
// then KERNEL_SIZE^2 coefficients) after a start request.
// Optional macro CFG_WRITER_BRESP_WAIT_EN: wait for each write response
// (WAIT_B state, bready only while waiting). Undefined: bready tied high,
// responses discarded.
module conv_cfg_writer #(
  parameter int DATA_WIDTH     = 8,
  parameter int KERNEL_SIZE    = 3,
  parameter int AXI_ADDR_WIDTH = 10
) (
  input  logic                                         Clk,
  input  logic                                         Rst,
  input  logic                                         start,
  input  logic [DATA_WIDTH-1:0]                        img_width,
  input  logic [DATA_WIDTH-1:0]                        img_height,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] coeff_flat,
  output logic                                         busy,
  output logic                                         done,
  output logic [4:0]                                   wr_index,
  output logic [AXI_ADDR_WIDTH-1:0]                    s_axi_awaddr,
  output logic                                         s_axi_awvalid,
  input  logic                                         s_axi_awready,
  output logic [DATA_WIDTH-1:0]                        s_axi_wdata,
  output logic                                         s_axi_wvalid,
  input  logic                                         s_axi_wready,
  input  logic                                         s_axi_bvalid,
  output logic                                         s_axi_bready
);

  localparam int         NCOEF     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int         NWR       = 4 + NCOEF;
  localparam logic [4:0] LAST_IDX  = 5'(NWR - 1);
  localparam int         COEF_BITS = NCOEF * DATA_WIDTH;

`ifdef CFG_WRITER_BRESP_WAIT_EN
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_B, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
`endif

  state_t                    state_q;
  logic                      start_q;
  logic                      busy_q;
  logic                      done_q;
  logic [4:0]                wr_index_q;
  logic [4:0]                wr_index_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic                      awvalid_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      wvalid_q;
  logic [DATA_WIDTH-1:0]     width_q;
  logic [DATA_WIDTH-1:0]     height_q;
  logic [COEF_BITS-1:0]      coeff_q;

  logic start_acc;
  logic aw_pend;
  logic w_pend;
  logic advance;

  // A request is a rising edge of start seen while idle, so a held start
  // launches only one sequence and a start during DONE is dropped.
  assign start_acc  = start & ~start_q & (state_q == S_IDLE);
  // A channel is still outstanding if its valid is up and ready is low.
  assign aw_pend    = awvalid_q & ~s_axi_awready;
  assign w_pend     = wvalid_q & ~s_axi_wready;
  assign wr_index_d = wr_index_q + 5'd1;

`ifdef CFG_WRITER_BRESP_WAIT_EN
  logic bready_q;
  assign advance      = (state_q == S_WAIT_B) & s_axi_bvalid;
  assign s_axi_bready = bready_q;
`else
  logic unused_bvalid;
  assign unused_bvalid = s_axi_bvalid;
  assign advance       = (state_q == S_ISSUE) & ~aw_pend & ~w_pend;
  assign s_axi_bready  = 1'b1;
`endif

  // Register address for write slot idx.
  function automatic logic [AXI_ADDR_WIDTH-1:0] addr_of(input logic [4:0] idx);
    case (idx)
      5'd0:    addr_of = AXI_ADDR_WIDTH'(4);
      5'd1:    addr_of = '0;
      5'd2:    addr_of = AXI_ADDR_WIDTH'(16);
      5'd3:    addr_of = AXI_ADDR_WIDTH'(20);
      default: addr_of = AXI_ADDR_WIDTH'(24) + (AXI_ADDR_WIDTH'(idx - 5'd4) << 2);
    endcase
  endfunction

  // Write data for slot idx, taken from the values captured at start.
  function automatic logic [DATA_WIDTH-1:0] data_of(input logic [4:0] idx);
    case (idx)
      5'd0, 5'd1: data_of = DATA_WIDTH'(1);
      5'd2:       data_of = width_q;
      5'd3:       data_of = height_q;
      default:    data_of = coeff_q[(int'(idx) - 4) * DATA_WIDTH +: DATA_WIDTH];
    endcase
  endfunction

  // Capture the image size and coefficients only when a request is accepted.
  always_ff @(posedge Clk) begin
    if (start_acc) begin
      width_q  <= img_width;
      height_q <= img_height;
      coeff_q  <= coeff_flat;
    end
  end

  // Sequencer: issues each write, tracks per-channel acceptance, steps slots.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_index_q <= '0;
      awaddr_q   <= '0;
      awvalid_q  <= 1'b0;
      wdata_q    <= '0;
      wvalid_q   <= 1'b0;
`ifdef CFG_WRITER_BRESP_WAIT_EN
      bready_q   <= 1'b0;
`endif
    end else begin
      start_q <= start;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_acc) begin
            state_q    <= S_ISSUE;
            busy_q     <= 1'b1;
            wr_index_q <= '0;
            awaddr_q   <= addr_of(5'd0);
            wdata_q    <= DATA_WIDTH'(1);
            awvalid_q  <= 1'b1;
            wvalid_q   <= 1'b1;
          end
        end
        S_ISSUE: begin
          // Each valid drops on its own handshake and is never re-raised.
          awvalid_q <= aw_pend;
          wvalid_q  <= w_pend;
`ifdef CFG_WRITER_BRESP_WAIT_EN
          if (!aw_pend && !w_pend) begin
            state_q  <= S_WAIT_B;
            bready_q <= 1'b1;
          end
`endif
        end
`ifdef CFG_WRITER_BRESP_WAIT_EN
        S_WAIT_B: begin
          if (s_axi_bvalid) bready_q <= 1'b0;
        end
`endif
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // Slot complete: either finish or load the next address/data pair.
      if (advance) begin
        if (wr_index_q == LAST_IDX) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end else begin
          state_q    <= S_ISSUE;
          wr_index_q <= wr_index_d;
          awaddr_q   <= addr_of(wr_index_d);
          wdata_q    <= data_of(wr_index_d);
          awvalid_q  <= 1'b1;
          wvalid_q   <= 1'b1;
        end
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign wr_index      = wr_index_q;
  assign s_axi_awaddr  = awaddr_q;
  assign s_axi_awvalid = awvalid_q;
  assign s_axi_wdata   = wdata_q;
  assign s_axi_wvalid  = wvalid_q;

endmodule
